// File: rtl/bpu_update_if.sv
// Bundles the resolved-branch inputs and the branch-target-cache write port.
// The updater uses the slave view; the execute stage and cache use the master view.
interface bpu_update_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WIDTH      = 32
);
    logic                  resolve_valid;
    logic [ADDR_WIDTH-1:0] resolve_pc;
    logic [WIDTH-1:0]      resolve_target;
    logic                  resolve_taken;
    logic                  pred_taken;
    logic [WIDTH-1:0]      pred_target;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      data_in0;
    logic [WIDTH-1:0]      data_in1;
    logic [1:0]            data_in2;
    logic                  write_en;
    logic                  hit2;
    logic [1:0]            data_out3;

    modport master (
        output resolve_valid, resolve_pc, resolve_target, resolve_taken,
        output pred_taken, pred_target,
        output hit2, data_out3,
        input  wr_addr, data_in0, data_in1, data_in2, write_en
    );

    modport slave (
        input  resolve_valid, resolve_pc, resolve_target, resolve_taken,
        input  pred_taken, pred_target,
        input  hit2, data_out3,
        output wr_addr, data_in0, data_in1, data_in2, write_en
    );
endinterface

// File: rtl/bpu_update.sv
// Branch-target cache updater: flags mispredicts, queues resolved branches and
// performs a lookup/write read-modify-write of the 2-bit counter for each one.
module bpu_update #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    bpu_update_if.slave      bus,
    output logic             flush,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             fifo_full,
    output logic [15:0]      drop_count
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [WIDTH-1:0]      target;
        logic                  taken;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    entry_t           mem [FIFO_DEPTH];
    entry_t           head;
    entry_t           head_next;
    entry_t           push_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             drop;
    logic             mispredict;
    logic [1:0]       ctr_next;
    logic             write_en_q;
    logic [1:0]       data_in2_q;

    // Queue bookkeeping; fullness is judged on the pre-edge count so a same-cycle pop never rescues a push.
    always_comb begin
        push        = bus.resolve_valid && (count != DEPTH_C);
        drop        = bus.resolve_valid && (count == DEPTH_C);
        pop         = (state == WRITE);
        count_next  = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        push_entry.pc     = bus.resolve_pc;
        push_entry.target = bus.resolve_target;
        push_entry.taken  = bus.resolve_taken;

        // Head seen after this edge: nothing, the entry being pushed into an empty queue, or stored data.
        if (count_next == '0) begin
            head_next = '0;
        end else if (push && ((count - CNT_W'(pop)) == '0)) begin
            head_next = push_entry;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_comb begin
        mispredict = bus.resolve_valid &&
                     ((bus.resolve_taken != bus.pred_taken) ||
                      (bus.resolve_taken && (bus.pred_target != bus.resolve_target)));
    end

    // Saturating counter step for the head entry; a miss allocates weak-taken.
    always_comb begin
        ctr_next = 2'b10;
        if (bus.hit2) begin
            if (head.taken) begin
                ctr_next = (bus.data_out3 == 2'b11) ? 2'b11 : bus.data_out3 + 2'b01;
            end else begin
                ctr_next = (bus.data_out3 == 2'b00) ? 2'b00 : bus.data_out3 - 2'b01;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = LOOKUP;
            LOOKUP:  state_next = WRITE;
            WRITE:   state_next = (count_next != '0) ? LOOKUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head      <= '0;
            fifo_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            head      <= head_next;
            fifo_full <= (count_next == DEPTH_C);
        end
    end

    // Payload storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            drop_count  <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= bus.resolve_taken ? bus.resolve_target
                                                 : WIDTH'(bus.resolve_pc) + WIDTH'(4);
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // The lookup result is folded into the write strobe and new state on the LOOKUP->WRITE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en_q <= 1'b0;
            data_in2_q <= 2'b00;
        end else begin
            write_en_q <= (state == LOOKUP) && (bus.hit2 || head.taken);
            if (state == LOOKUP) begin
                data_in2_q <= ctr_next;
            end
        end
    end

    assign bus.wr_addr  = head.pc;
    assign bus.data_in0 = WIDTH'(head.pc);
    assign bus.data_in1 = head.target;
    assign bus.data_in2 = data_in2_q;
    assign bus.write_en = write_en_q;
endmodule
